// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags, a same-cycle
// commit bypass on both read ports, and a flush that drops every pending tag.
module reg_file #(
  parameter int                  ROB_SIZE_WIDTH = 5,
  parameter logic [ROB_SIZE_WIDTH:0] DEP_NONE   = '1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      commit_valid_in,
  input  logic [4:0]                commit_rd_in,
  input  logic [31:0]               commit_value_in,
  input  logic [ROB_SIZE_WIDTH:0]   commit_dep_in,
  input  logic                      rename_valid_in,
  input  logic [4:0]                rename_rd_in,
  input  logic [ROB_SIZE_WIDTH:0]   rename_dep_in,
  input  logic [4:0]                rs1_in,
  input  logic [4:0]                rs2_in,
  output logic [31:0]               rs1_value_out,
  output logic [31:0]               rs2_value_out,
  output logic [ROB_SIZE_WIDTH:0]   rs1_dep_out,
  output logic [ROB_SIZE_WIDTH:0]   rs2_dep_out
);

  localparam int DW = ROB_SIZE_WIDTH + 1;

  logic [31:0]   value_q [32];
  logic [31:0]   value_d [32];
  logic [DW-1:0] tag_q   [32];
  logic [DW-1:0] tag_d   [32];

  // Entry 0 is only ever loaded by reset, so it permanently reads 0 / DEP_NONE.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      value_d[i] = value_q[i];
      tag_d[i]   = tag_q[i];
    end
    for (int i = 1; i < 32; i++) begin
      if (commit_valid_in && (commit_rd_in == 5'(i))) begin
        value_d[i] = commit_value_in;
      end
      if (flush_in) begin
        tag_d[i] = DEP_NONE;
      end else if (rename_valid_in && (rename_rd_in == 5'(i))) begin
        tag_d[i] = rename_dep_in;
      end else if (commit_valid_in && (commit_rd_in == 5'(i)) &&
                   (tag_q[i] == commit_dep_in)) begin
        tag_d[i] = DEP_NONE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= DEP_NONE;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  // A retiring entry that is still the register's youngest writer is forwarded.
  logic [4:0]    rs_idx  [2];
  logic [31:0]   rs_val  [2];
  logic [DW-1:0] rs_dep  [2];

  assign rs_idx[0] = rs1_in;
  assign rs_idx[1] = rs2_in;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rs_val[gi] = value_q[rs_idx[gi]];
        rs_dep[gi] = tag_q[rs_idx[gi]];
        if (commit_valid_in && (rs_idx[gi] != 5'd0) &&
            (commit_rd_in == rs_idx[gi]) &&
            (tag_q[rs_idx[gi]] == commit_dep_in)) begin
          rs_val[gi] = commit_value_in;
          rs_dep[gi] = DEP_NONE;
        end
      end
    end
  endgenerate

  assign rs1_value_out = rs_val[0];
  assign rs1_dep_out   = rs_dep[0];
  assign rs2_value_out = rs_val[1];
  assign rs2_dep_out   = rs_dep[1];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against an array model.
module tb_reg_file;
  localparam int RW = 5;
  localparam int DW = RW + 1;
  localparam logic [DW-1:0] NONE = '1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rdy_in = 1'b0;
  logic          flush_in = 1'b0;
  logic          commit_valid_in = 1'b0;
  logic [4:0]    commit_rd_in = '0;
  logic [31:0]   commit_value_in = '0;
  logic [DW-1:0] commit_dep_in = '0;
  logic          rename_valid_in = 1'b0;
  logic [4:0]    rename_rd_in = '0;
  logic [DW-1:0] rename_dep_in = '0;
  logic [4:0]    rs1_in = '0;
  logic [4:0]    rs2_in = '0;
  logic [31:0]   rs1_value_out, rs2_value_out;
  logic [DW-1:0] rs1_dep_out, rs2_dep_out;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  reg_file #(.ROB_SIZE_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .commit_valid_in(commit_valid_in), .commit_rd_in(commit_rd_in),
    .commit_value_in(commit_value_in), .commit_dep_in(commit_dep_in),
    .rename_valid_in(rename_valid_in), .rename_rd_in(rename_rd_in),
    .rename_dep_in(rename_dep_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rs1_value_out(rs1_value_out), .rs2_value_out(rs2_value_out),
    .rs1_dep_out(rs1_dep_out), .rs2_dep_out(rs2_dep_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference state: architectural values and youngest-writer tags.
  logic [31:0]   m_val [32];
  logic [DW-1:0] m_tag [32];

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] <= '0;
        m_tag[i] <= NONE;
      end
    end else if (rdy_in) begin
      if (commit_valid_in && commit_rd_in != 0)
        m_val[commit_rd_in] <= commit_value_in;
      if (flush_in) begin
        for (int i = 0; i < 32; i++) m_tag[i] <= NONE;
      end else begin
        if (commit_valid_in && commit_rd_in != 0 && m_tag[commit_rd_in] == commit_dep_in)
          m_tag[commit_rd_in] <= NONE;
        if (rename_valid_in && rename_rd_in != 0)
          m_tag[rename_rd_in] <= rename_dep_in;
      end
    end
  end

  function automatic void model_read(input logic [4:0] rs,
                                     output logic [31:0] v, output logic [DW-1:0] d);
    if (rs == 0) begin
      v = '0; d = NONE;
    end else if (commit_valid_in && commit_rd_in == rs && m_tag[rs] == commit_dep_in) begin
      v = commit_value_in; d = NONE;
    end else begin
      v = m_val[rs]; d = m_tag[rs];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    logic [31:0]   v1, v2;
    logic [DW-1:0] d1, d2;
    if (check_en) begin
      model_read(rs1_in, v1, d1);
      model_read(rs2_in, v2, d2);
      chk("model_rs1_value", rs1_value_out, v1);
      chk("model_rs1_dep", 32'(rs1_dep_out), 32'(d1));
      chk("model_rs2_value", rs2_value_out, v2);
      chk("model_rs2_dep", 32'(rs2_dep_out), 32'(d2));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0;
    commit_valid_in = 1'b0; rename_valid_in = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [DW-1:0] d);
    commit_valid_in = 1'b1; commit_rd_in = rd; commit_value_in = v; commit_dep_in = d;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [DW-1:0] d);
    rename_valid_in = 1'b1; rename_rd_in = rd; rename_dep_in = d;
  endtask

  task automatic rd1(input string name, input logic [4:0] rs,
                     input logic [31:0] v, input logic [DW-1:0] d);
    rs1_in = rs;
    #1;
    chk({name, "_value"}, rs1_value_out, v);
    chk({name, "_dep"}, 32'(rs1_dep_out), 32'(d));
  endtask

  initial begin
    idle();
    rdy_in = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    chk("reset_x5_value", rs1_value_out, 32'h0);
    #20 rst_in = 1'b1;
    check_en = 1'b1;
    tick();
    idle();
    rd1("reset_x31", 5'd31, 32'h0, NONE);

    // Rename then commit with matching tag: bypass, then stored.
    rename(5'd5, 6'd3); tick(); idle();
    rd1("ren_x5", 5'd5, 32'h0, 6'd3);
    commit(5'd5, 32'h1234, 6'd3);
    rd1("bypass_x5", 5'd5, 32'h1234, NONE);
    tick(); idle();
    rd1("stored_x5", 5'd5, 32'h1234, NONE);
    $display("txn: rename/commit x5 done");

    // Stale commit keeps the newer tag.
    rename(5'd7, 6'd2); tick(); idle();
    rename(5'd7, 6'd9); tick(); idle();
    commit(5'd7, 32'hAA, 6'd2);
    rd1("stale_nobypass_x7", 5'd7, 32'h0, 6'd9);
    tick(); idle();
    rd1("stale_x7", 5'd7, 32'hAA, 6'd9);
    $display("txn: stale commit x7 done");

    // Same-cycle commit and rename of x4.
    rename(5'd4, 6'd1); tick(); idle();
    commit(5'd4, 32'h55, 6'd1); rename(5'd4, 6'd6); rs2_in = 5'd4;
    rd1("same_cycle_x4", 5'd4, 32'h55, NONE);
    chk("same_cycle_x4_rs2_value", rs2_value_out, 32'h55);
    chk("same_cycle_x4_rs2_dep", 32'(rs2_dep_out), 32'(NONE));
    tick(); idle();
    rd1("after_x4", 5'd4, 32'h55, 6'd6);
    $display("txn: commit+rename x4 done");

    // Flush with commit and rename in the same cycle.
    for (int i = 1; i < 32; i++) begin
      rename(5'(i), 6'(i)); tick(); idle();
    end
    rd1("pre_flush_x20", 5'd20, 32'h0, 6'd20);
    flush_in = 1'b1; commit(5'd2, 32'h77, 6'd50); rename(5'd3, 6'd4);
    tick(); idle();
    for (int i = 1; i < 32; i++) begin
      rs1_in = 5'(i);
      #1 chk("flush_tag", 32'(rs1_dep_out), 32'(NONE));
    end
    rd1("flush_x2", 5'd2, 32'h77, NONE);
    $display("txn: flush done");

    // x0 is hardwired.
    commit(5'd0, 32'hFFFFFFFF, 6'd1); rename(5'd0, 6'd1);
    rd1("x0_same", 5'd0, 32'h0, NONE);
    tick(); idle();
    rd1("x0_after", 5'd0, 32'h0, NONE);
    $display("txn: x0 done");

    // rdy_in low freezes state.
    rdy_in = 1'b0; commit(5'd9, 32'h99, 6'd5); rename(5'd9, 6'd5);
    tick(); idle();
    rd1("frozen_x9", 5'd9, 32'h0, NONE);
    $display("txn: rdy low done");

    // Asynchronous reset between edges, held across an edge with a commit pending.
    commit(5'd10, 32'hBEEF, 6'd0); tick(); idle();
    rd1("pre_rst_x10", 5'd10, 32'hBEEF, NONE);
    rst_in = 1'b0;
    rd1("async_rst_x10", 5'd10, 32'h0, NONE);
    rd1("async_rst_x5", 5'd5, 32'h0, NONE);
    commit(5'd12, 32'h12, 6'd0); rename(5'd12, 6'd8);
    tick();
    idle(); rst_in = 1'b1;
    rd1("rst_discard_x12", 5'd12, 32'h0, NONE);
    rename(5'd11, 6'd7); tick(); idle();
    rd1("post_rst_x11", 5'd11, 32'h0, 6'd7);
    $display("txn: reset done");

    // Randomized phase checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      rdy_in          = ($urandom_range(0, 9) != 0);
      flush_in        = ($urandom_range(0, 19) == 0);
      commit_valid_in = $urandom_range(0, 1) == 1;
      commit_rd_in    = 5'($urandom_range(0, 31));
      commit_value_in = $urandom;
      commit_dep_in   = 6'($urandom_range(0, 7));
      rename_valid_in = $urandom_range(0, 1) == 1;
      rename_rd_in    = 5'($urandom_range(0, 31));
      rename_dep_in   = 6'($urandom_range(0, 7));
      rs1_in          = 5'($urandom_range(0, 31));
      rs2_in          = ($urandom_range(0, 3) == 0) ? rs1_in : 5'($urandom_range(0, 31));
      tick();
    end
    $display("txn: random phase done");
    idle();
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
